imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Elastic, parametrised immediate-generation stage for the decode path. Takes full 32-bit
//  instruction words plus a sideband tag over valid/ready. Emits the sign/zero-extended
//  XLEN-bit immediate, a format code and the tag after STAGES register stages.
//  Covers all RV32I/RV64I immediate formats, including shift-amount handling.
// PARAMETERS
//  XLEN    32  immediate output width; legal values 32 or 64
//  STAGES  1   register stages between input and output; legal values 1 or 2
//  TAG_W   32  sideband tag width (PC or ROB id), carried unmodified
// PORTS
//  clk          in   1       clock; all state on the rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  flush        in   1       synchronous kill of every in-flight entry
//  in_valid     in   1       input word valid
//  in_ready     out  1       stage can accept the input word
//  in_instr     in   32      instruction word
//  in_tag       in   TAG_W   sideband tag
//  out_valid    out  1       output valid
//  out_ready    in   1       downstream accepts the output
//  out_imm      out  XLEN    immediate
//  out_fmt      out  3       0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
//  out_tag      out  TAG_W   tag travelling with the immediate
//  out_illegal  out  1       illegal shift-immediate encoding (see CONFIGURATION)
// BEHAVIOUR
//  Decode (combinational, at input, on opcode = in_instr[6:0]):
//   0000011/1100111/1110011, and 0010011 with funct3 not 001/101 -> I: sext(instr[31:20])
//   0100011 -> S: sext({instr[31:25],instr[11:7]})
//   1100011 -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//   0110111/0010111 -> U: sext({instr[31:12],12'b0}); at XLEN=32 no extension
//   1101111 -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//   0010011 with funct3 001/101 -> SHAMT: zext shamt; shamt width 5 (XLEN=32), 6 (XLEN=64)
//   0011011 (XLEN=64 only) -> funct3 001/101: SHAMT with 5-bit shamt; other funct3: I
//   any other opcode (incl. 0011011 at XLEN=32) -> NONE, imm = 0
//  Pipeline:
//   - STAGES identical slots, each holding valid+imm+fmt+tag+illegal.
//   - A slot loads when it is empty or its contents move forward this cycle.
//   - in_ready = !v[0] | advance[0]. Last slot advances on out_valid & out_ready.
//   - Transfer on in_valid & in_ready. Latency STAGES cycles; full throughput, 1 word/cycle.
//   - Output holds stable while out_valid & !out_ready; out_valid never drops without a transfer.
//   - in_ready is combinational from out_ready; no combinational in_valid->out_valid path.
//  flush:
//   - All valids clear at the next edge.
//   - in_ready is 0 during a flush cycle; input is discarded.
//   - Flush wins over a simultaneous accept or output transfer.
//  Reset: all valids, imm, fmt, tag and illegal go to 0 immediately. After reset, in_ready = 1.
//  Reset mid-stream drops all entries; there is no replay.
// CONFIGURATION
//  IMMGEN_ILLEGAL_CHK_EN defined: out_illegal = 1 for a SHAMT word in either case below;
//   imm and fmt are still produced normally.
//   - funct3=001 with instr[31:26] (XLEN=64) or instr[31:25] (XLEN=32) not all zero
//   - funct3=101 with those bits not 000000/0100000 (or 0000000/0100000)
//   - For 0011011: instr[31:25] must be 0000000 or 0100000.
//  Macro undefined: out_illegal is tied to 0 and no check logic exists.
// TESTING
//  XLEN=32 ADDI 0xFFF00093 -> imm 0xFFFFFFFF, fmt 1, valid exactly STAGES cycles later
//  SW 0xFE112E23 -> imm 0xFFFFFFFC, fmt 2; BEQ 0xFE000CE3 -> 0xFFFFFFF8, fmt 3
//  JAL 0x0010006F -> imm 0x00000800, fmt 5; LUI 0xABCDE2B7 -> 0xABCDE000 (XLEN=64: 0xFFFFFFFFABCDE000)
//  SRAI 0x4030D093 -> imm 3, fmt 6, illegal 0; 0x4230D093 -> illegal 1 with macro, 0 without
//  STAGES=2, out_ready=0 for 4 cycles, back-to-back input -> 2 held, in_ready 0, order and tags kept
//  flush while 2 entries held plus in_valid=1 -> out_valid 0 next cycle, nothing emitted later

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Elastic RV32I/RV64I immediate generator, STAGES-deep valid/ready pipe.
// Define IMMGEN_ILLEGAL_CHK_EN to flag reserved shift-immediate encodings.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;

  localparam logic IS64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } slot_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        sh_f3;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic        is_sh;
  logic [5:0]  sh6;
  logic [63:0] imm64;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  slot_t       dec;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign sh_f3 = (f3 == 3'b001) | (f3 == 3'b101);

  assign is_i = (opc == OP_LOAD) | (opc == OP_JALR)
              | (opc == OP_SYS)
              | ((opc == OP_IMM) & !sh_f3)
              | (IS64 & (opc == OP_IMM32) & !sh_f3);
  assign is_sh = ((opc == OP_IMM) & sh_f3)
               | (IS64 & (opc == OP_IMM32) & sh_f3);
  assign is_s = (opc == OP_STORE);
  assign is_b = (opc == OP_BR);
  assign is_u = (opc == OP_LUI) | (opc == OP_AUIPC);
  assign is_j = (opc == OP_JAL);

  // 64-bit shifts on OP-IMM use a 6-bit shamt; W forms use 5.
  assign sh6 = (IS64 && (opc == OP_IMM))
             ? in_instr[25:20]
             : {1'b0, in_instr[24:20]};

  // Assemble the 64-bit immediate for whichever format matched.
  always_comb begin
    imm64   = '0;
    dec_fmt = FMT_NONE;
    unique case (1'b1)
      is_i: begin
        imm64   = {{52{in_instr[31]}}, in_instr[31:20]};
        dec_fmt = FMT_I;
      end
      is_s: begin
        imm64   = {{52{in_instr[31]}}, in_instr[31:25],
                   in_instr[11:7]};
        dec_fmt = FMT_S;
      end
      is_b: begin
        imm64   = {{51{in_instr[31]}}, in_instr[31],
                   in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      is_u: begin
        imm64   = {{32{in_instr[31]}}, in_instr[31:12],
                   12'b0};
        dec_fmt = FMT_U;
      end
      is_j: begin
        imm64   = {{43{in_instr[31]}}, in_instr[31],
                   in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      is_sh: begin
        imm64   = {58'b0, sh6};
        dec_fmt = FMT_SH;
      end
      default: begin
        imm64   = '0;
        dec_fmt = FMT_NONE;
      end
    endcase
  end

`ifdef IMMGEN_ILLEGAL_CHK_EN
  logic [6:0] hi7;
  logic [5:0] hi6;

  assign hi7 = in_instr[31:25];
  assign hi6 = in_instr[31:26];

  // Reserved upper bits on a shift-immediate mark it illegal.
  always_comb begin
    dec_ill = 1'b0;
    if (is_sh) begin
      if (opc == OP_IMM32)
        dec_ill = !((hi7 == 7'h00) || (hi7 == 7'h20));
      else if (IS64)
        dec_ill = (f3 == 3'b001)
                ? (hi6 != 6'h00)
                : !((hi6 == 6'h00) || (hi6 == 6'h10));
      else
        dec_ill = (f3 == 3'b001)
                ? (hi7 != 7'h00)
                : !((hi7 == 7'h00) || (hi7 == 7'h20));
    end
  end
`else
  assign dec_ill = 1'b0;
`endif

  assign dec = '{imm: XLEN'(imm64), fmt: dec_fmt,
                 tag: in_tag, ill: dec_ill};

  logic  [STAGES-1:0] v_q;
  logic  [STAGES-1:0] v_d;
  logic  [STAGES-1:0] ld;
  logic  [STAGES-1:0] nv;
  slot_t [STAGES-1:0] s_q;
  slot_t [STAGES-1:0] s_d;
  slot_t [STAGES-1:0] ns;

  // Ready ripples back from the output; each slot shifts forward.
  always_comb begin
    logic [STAGES:0] rdy;
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--)
      rdy[i] = !v_q[i] | rdy[i+1];
    ld       = rdy[STAGES-1:0];
    in_ready = rdy[0] & !flush;
    nv       = '0;
    ns       = '0;
    nv[0]    = in_valid & in_ready;
    ns[0]    = dec;
    for (int i = 1; i < STAGES; i++) begin
      nv[i] = v_q[i-1];
      ns[i] = s_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      v_d[i] = flush ? 1'b0 : (ld[i] ? nv[i] : v_q[i]);
      s_d[i] = (ld[i] & nv[i]) ? ns[i] : s_q[i];
    end
  end

  // Slot registers; reset empties the pipe and zeroes payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      s_q <= '0;
    end else begin
      v_q <= v_d;
      s_q <= s_d;
    end
  end

  assign out_valid   = v_q[STAGES-1];
  assign out_imm     = s_q[STAGES-1].imm;
  assign out_fmt     = s_q[STAGES-1].fmt;
  assign out_tag     = s_q[STAGES-1].tag;
  assign out_illegal = s_q[STAGES-1].ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: random words vs. a spec model.
// Honours IMMGEN_ILLEGAL_CHK_EN when building expected illegal flags.
module tb_imm_gen_pipe;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 32;

`ifdef IMMGEN_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  int   total = 0;
  int   bad   = 0;
  bit   run   = 0;
  exp_t q[$];

  imm_gen_pipe #(
    .XLEN  (XLEN),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_tag    (out_tag),
    .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w,
                                 input logic [TAG_W-1:0] tg);
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  hi7;
    logic [5:0]  hi6;
    bit          sh;
    longint      v;
    op  = w[6:0];
    f3  = w[14:12];
    hi7 = w[31:25];
    hi6 = w[31:26];
    sh  = (f3 == 3'd1) || (f3 == 3'd5);
    v   = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = tg;
    case (op)
      7'h03, 7'h67, 7'h73: begin
        v = longint'($signed(w[31:20]));
        e.fmt = 3'd1;
      end
      7'h13: begin
        if (sh) begin
          v = (XLEN == 64) ? longint'(w[25:20])
                           : longint'(w[24:20]);
          e.fmt = 3'd6;
          if (XLEN == 64)
            e.ill = (f3 == 3'd1) ? (hi6 != 0)
                  : !(hi6 == 0 || hi6 == 6'h10);
          else
            e.ill = (f3 == 3'd1) ? (hi7 != 0)
                  : !(hi7 == 0 || hi7 == 7'h20);
        end else begin
          v = longint'($signed(w[31:20]));
          e.fmt = 3'd1;
        end
      end
      7'h1B: begin
        if (XLEN == 64 && sh) begin
          v = longint'(w[24:20]);
          e.fmt = 3'd6;
          e.ill = !(hi7 == 0 || hi7 == 7'h20);
        end else if (XLEN == 64) begin
          v = longint'($signed(w[31:20]));
          e.fmt = 3'd1;
        end
      end
      7'h23: begin
        v = longint'($signed({w[31:25], w[11:7]}));
        e.fmt = 3'd2;
      end
      7'h63: begin
        v = 2 * longint'($signed({w[31], w[7],
                                  w[30:25], w[11:8]}));
        e.fmt = 3'd3;
      end
      7'h37, 7'h17: begin
        v = 4096 * longint'($signed(w[31:12]));
        e.fmt = 3'd4;
      end
      7'h6F: begin
        v = 2 * longint'($signed({w[31], w[19:12],
                                  w[20], w[30:21]}));
        e.fmt = 3'd5;
      end
      default: v = 0;
    endcase
    if (!CHK) e.ill = 1'b0;
    e.imm = v;
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] imm,
                              input logic [2:0] fmt,
                              input logic [TAG_W-1:0] tg,
                              input logic ill);
    exp_t e;
    e.imm = imm;
    e.fmt = fmt;
    e.tag = tg;
    e.ill = ill;
    return e;
  endfunction

  task automatic step(input logic v,
                      input logic [31:0] ins,
                      input logic [TAG_W-1:0] tg,
                      input logic ordy,
                      input logic fl,
                      input exp_t e);
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (fl) q.delete();
    else if (in_valid && in_ready) q.push_back(e);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, '0, ordy, 1'b0, mk(0, 0, 0, 0));
  endtask

  // Monitor: pops on every output transfer, checks hold on stall.
  initial begin
    exp_t             e;
    bit               stall;
    logic [XLEN-1:0]  p_imm;
    logic [TAG_W-1:0] p_tag;
    logic [2:0]       p_fmt;
    stall = 0;
    p_imm = '0;
    p_tag = '0;
    p_fmt = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!run) begin
        stall = 0;
        continue;
      end
      if (stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_imm", 64'(out_imm), 64'(p_imm));
        chk("hold_tag", 64'(out_tag), 64'(p_tag));
        chk("hold_fmt", 64'(out_fmt), 64'(p_fmt));
      end
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_tag), 64'hDEAD);
        end else begin
          e = q.pop_front();
          chk("imm", 64'(out_imm), 64'(e.imm[XLEN-1:0]));
          chk("fmt", 64'(out_fmt), 64'(e.fmt));
          chk("tag", 64'(out_tag), 64'(e.tag));
          chk("ill", 64'(out_illegal), 64'(e.ill));
        end
      end
      stall = out_valid && !out_ready && !flush;
      p_imm = out_imm;
      p_tag = out_tag;
      p_fmt = out_fmt;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      w;
    logic [TAG_W-1:0] tg;
    logic [6:0]       ops [12];
    logic [63:0]      lui_exp;
    int               n;
    ops = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h13, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h33};
    lui_exp = (XLEN == 64) ? 64'hFFFFFFFFABCDE000
                           : 64'h00000000ABCDE000;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_imm", 64'(out_imm), 64'(0));
    chk("rst_fmt", 64'(out_fmt), 64'(0));
    chk("rst_tag", 64'(out_tag), 64'(0));
    chk("rst_ill", 64'(out_illegal), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    run   = 1'b1;

    // Latency: ADDI x1,x0,-1 appears exactly STAGES cycles later.
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0,
         mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 32'h100, 1'b0));
    for (int k = 1; k <= STAGES; k++) begin
      idle(1'b1);
      chk("latency", 64'(out_valid), 64'(k == STAGES));
    end

    // Directed encodings, back to back.
    step(1'b1, 32'hFE112E23, 32'h101, 1'b1, 1'b0,
         mk(64'hFFFFFFFFFFFFFFFC, 3'd2, 32'h101, 1'b0));
    step(1'b1, 32'hFE000CE3, 32'h102, 1'b1, 1'b0,
         mk(64'hFFFFFFFFFFFFFFF8, 3'd3, 32'h102, 1'b0));
    step(1'b1, 32'h0010006F, 32'h103, 1'b1, 1'b0,
         mk(64'h800, 3'd5, 32'h103, 1'b0));
    step(1'b1, 32'hABCDE2B7, 32'h104, 1'b1, 1'b0,
         mk(lui_exp, 3'd4, 32'h104, 1'b0));
    step(1'b1, 32'h4030D093, 32'h105, 1'b1, 1'b0,
         mk(64'd3, 3'd6, 32'h105, 1'b0));
    step(1'b1, 32'h4230D093, 32'h106, 1'b1, 1'b0,
         mk(64'd3, 3'd6, 32'h106, CHK));
    step(1'b1, 32'h0000007F, 32'h107, 1'b1, 1'b0,
         mk(64'd0, 3'd0, 32'h107, 1'b0));
    repeat (4) idle(1'b1);
    chk("directed_drain", 64'(q.size()), 64'(0));

    // Stall: back-to-back input with out_ready low.
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 32'h00500093 + 32'(k << 20), 32'h200 + k,
           1'b0, 1'b0, mk(64'(5 + k), 3'd1, 32'h200 + k, 1'b0));
      chk("stall_in_ready", 64'(in_ready), 64'(k <= STAGES));
    end
    repeat (5) idle(1'b1);
    chk("stall_drain", 64'(q.size()), 64'(0));

    // Flush with held entries and a simultaneous input.
    for (int k = 1; k <= 2; k++)
      step(1'b1, 32'h00100093, 32'h300 + k, 1'b0, 1'b0,
           mk(64'd1, 3'd1, 32'h300 + k, 1'b0));
    step(1'b1, 32'h00100093, 32'h3FF, 1'b1, 1'b1,
         mk(64'd1, 3'd1, 32'h3FF, 1'b0));
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk("flush_out_valid", 64'(out_valid), 64'(0));
    end

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 1) == 1)
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      tg = $urandom;
      step($urandom_range(0, 3) != 0, w, tg,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0, model(w, tg));
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    chk("random_drain", 64'(q.size()), 64'(0));

    // Asynchronous reset with entries in flight.
    for (int k = 1; k <= 2; k++)
      step(1'b1, 32'hFFF00093, 32'h400 + k, 1'b0, 1'b0,
           mk(64'hFFFFFFFFFFFFFFFF, 3'd1, 32'h400 + k, 1'b0));
    run      = 1'b0;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_imm", 64'(out_imm), 64'(0));
    chk("arst_tag", 64'(out_tag), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk("post_rst_valid", 64'(out_valid), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
